// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the mem_responder data RAM.
//   state_e      - responder FSM states
//   size_e       - access size codes
//   req_fields_t - request fields captured at acceptance
//   LANE_MASK_*  - right-aligned data masks per access size
//   BE_*         - byte-enable patterns for a lane-0 access per size
package mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW,
        RSP,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        size_e       size;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } req_fields_t;

    // Right-aligned data mask for an access size.
    function automatic logic [31:0] size_mask(input size_e sz);
        case (sz)
            SZ_BYTE: size_mask = LANE_MASK_BYTE;
            SZ_HALF: size_mask = LANE_MASK_HALF;
            default: size_mask = LANE_MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane steering for mem_responder.
//   lane_i      - byte lane of the access (address bits [1:0])
//   size_i      - access size
//   rd_word_i   - word read from the RAM
//   st_data_i   - store data, right-aligned
//   ld_data_c_o - load data: rd_word_i shifted down to lane 0 and masked to size
//   wr_word_c_o - word to write into the RAM
//   wr_be_c_o   - per-byte write enables for wr_word_c_o
// Build option MEM_RESP_BYTE_ENABLE_EN: when defined, store data is shifted into
// its lane and byte enables select the bytes; otherwise the store data is merged
// into rd_word_i and the whole word is written.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_c_o,
    output logic [31:0] wr_word_c_o,
    output logic [3:0]  wr_be_c_o
);

    logic [4:0]  shamt;
    logic [31:0] mask;
`ifndef MEM_RESP_BYTE_ENABLE_EN
    logic [31:0] lane_mask;
`endif

    always_comb begin
        shamt       = {lane_i, 3'b000};
        mask        = size_mask(size_i);
        ld_data_c_o = (rd_word_i >> shamt) & mask;
`ifdef MEM_RESP_BYTE_ENABLE_EN
        wr_word_c_o = (st_data_i & mask) << shamt;
        case (size_i)
            SZ_BYTE: wr_be_c_o = BE_BYTE << lane_i;
            SZ_HALF: wr_be_c_o = BE_HALF << lane_i;
            default: wr_be_c_o = BE_WORD;
        endcase
`else
        // Keep the bytes outside the accessed lanes, replace the ones inside.
        lane_mask   = mask << shamt;
        wr_word_c_o = (rd_word_i & ~lane_mask) | ((st_data_i & mask) << shamt);
        wr_be_c_o   = BE_WORD;
`endif
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised single-port data RAM answering the core's memory
// port with byte/halfword/word loads and stores.
//   CLK, RST     - clock, synchronous active-high reset (RAM contents kept)
//   req_valid    - request present; accepted when req_ready is also high
//   req_ready    - high only in IDLE and outside reset
//   req_addr     - byte address (BASE_ADDR maps to word 0)
//   req_write    - 1 = store, 0 = load
//   req_byte/req_halfword/req_word - one-hot access size
//   req_wdata    - store data, right-aligned
//   resp_valid   - single-cycle response pulse
//   resp_rdata   - load data right-aligned, upper bits zero; zero otherwise
//   resp_err     - response is a rejection (misaligned, bad size, out of range)
// Build option MEM_RESP_BYTE_ENABLE_EN: sub-word stores use per-byte write enables
// and complete in one cycle; without it they go through a read-modify-write.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_halfword,
    input  logic        req_word,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;

    state_e          state_q, state_d;
    req_fields_t     req_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     rdata_q;

    logic [31:0]     off_c;
    size_e           dec_size_c;
    logic            dec_onehot_c;
    logic            dec_err_c;
    logic [AW-1:0]   dec_idx_c;
    logic [1:0]      dec_lane_c;
    logic            accept_c;

    logic [1:0]      al_lane_c;
    size_e           al_size_c;
    logic [31:0]     al_st_data_c;
    logic [31:0]     ld_data_c;
    logic [31:0]     wr_word_c;
    logic [3:0]      wr_be_c;

    logic            ram_we_c;
    logic [AW-1:0]   ram_waddr_c;

    assign req_ready = (state_q == IDLE) && !RST;
    assign accept_c  = req_valid && req_ready;

    // Request decode; off wraps modulo 2^32 so addresses below the base fail the range check.
    always_comb begin
        off_c        = req_addr - BASE_ADDR;
        dec_size_c   = SZ_WORD;
        dec_onehot_c = 1'b1;
        case ({req_word, req_halfword, req_byte})
            3'b001:  dec_size_c = SZ_BYTE;
            3'b010:  dec_size_c = SZ_HALF;
            3'b100:  dec_size_c = SZ_WORD;
            default: dec_onehot_c = 1'b0;
        endcase
        dec_err_c  = !dec_onehot_c
                   || (req_halfword && off_c[0])
                   || (req_word && (off_c[1:0] != 2'b00))
                   || ({1'b0, off_c} >= RANGE_BYTES);
        dec_idx_c  = off_c[AW+1:2];
        dec_lane_c = off_c[1:0];
    end

    // Lane steering sees the live request in IDLE and the captured one afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            al_lane_c    = dec_lane_c;
            al_size_c    = dec_size_c;
            al_st_data_c = req_wdata;
            ram_waddr_c  = dec_idx_c;
        end else begin
            al_lane_c    = req_q.lane;
            al_size_c    = req_q.size;
            al_st_data_c = req_q.wdata;
            ram_waddr_c  = idx_q;
        end
    end

    mem_lane_align u_align (
        .lane_i      (al_lane_c),
        .size_i      (al_size_c),
        .rd_word_i   (rdata_q),
        .st_data_i   (al_st_data_c),
        .ld_data_c_o (ld_data_c),
        .wr_word_c_o (wr_word_c),
        .wr_be_c_o   (wr_be_c)
    );

    // FSM next state, RAM write strobe and response outputs.
    always_comb begin
        state_d    = state_q;
        ram_we_c   = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (dec_err_c) begin
                        state_d = ERR;
                    end else if (!req_write) begin
                        state_d = RD;
`ifdef MEM_RESP_BYTE_ENABLE_EN
                    end else begin
                        state_d  = WR;
                        ram_we_c = 1'b1;
                    end
`else
                    end else if (dec_size_c == SZ_WORD) begin
                        state_d  = WR;
                        ram_we_c = 1'b1;
                    end else begin
                        state_d = RMW;
                    end
`endif
                end
            end
            RD: begin
                resp_valid = 1'b1;
                resp_rdata = ld_data_c;
                state_d    = IDLE;
            end
            WR: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
`ifndef MEM_RESP_BYTE_ENABLE_EN
            RMW: begin
                ram_we_c = 1'b1;
                state_d  = RSP;
            end
            RSP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
`endif
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture: later input changes cannot disturb an in-flight access.
    always_ff @(posedge CLK) begin
        if (accept_c) begin
            req_q.size  <= dec_size_c;
            req_q.lane  <= dec_lane_c;
            req_q.wdata <= req_wdata;
            idx_q       <= dec_idx_c;
        end
    end

    // RAM: not reset; a write coinciding with reset is dropped.
    always_ff @(posedge CLK) begin
        if (ram_we_c && !RST) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_c[b]) begin
                    mem_q[ram_waddr_c][8*b +: 8] <= wr_word_c[8*b +: 8];
                end
            end
        end
        if (accept_c) begin
            rdata_q <= mem_q[dec_idx_c];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a
// byte-addressed little-endian memory model.
module tb_mem_responder;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned NBYTES = DEPTH * 4;
`ifdef MEM_RESP_BYTE_ENABLE_EN
    localparam int SUB_LAT = 1;
`else
    localparam int SUB_LAT = 2;
`endif

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic        req_byte;
    logic        req_halfword;
    logic        req_word;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    bit [7:0] ref_mem [NBYTES];

    mem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_byte     (req_byte),
        .req_halfword (req_halfword),
        .req_word     (req_word),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: sz is {word,half,byte}; legal accesses are naturally aligned and in range.
    function automatic void ref_access(input logic [31:0] addr, input bit wr, input bit [2:0] sz,
                                       input logic [31:0] wd, output logic [31:0] rd,
                                       output bit er, output int lat);
        logic [31:0] off;
        int n;
        off = addr - BASE;
        n   = (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : (sz == 3'd4) ? 4 : 0;
        rd  = 32'h0;
        lat = 1;
        er  = (n == 0) || (off >= NBYTES) || ((off % n) != 0);
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
                if (n < 4) lat = SUB_LAT;
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[int'(off) + i];
            end
        end
    endfunction

    task automatic scramble_inputs();
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom);
        {req_word, req_halfword, req_byte} = 3'($urandom);
    endtask

    task automatic xact(input logic [31:0] addr, input bit wr, input bit [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output bit er,
                        output int lat);
        int w;
        rd  = 32'h0;
        er  = 1'b0;
        lat = 0;
        @(negedge CLK);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        {req_word, req_halfword, req_byte} = sz;
        req_wdata = wd;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge CLK);
            w++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        scramble_inputs();
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
        @(negedge CLK);
        check_eq("pulse_end", {resp_valid, resp_err, resp_rdata[29:0]}, 32'h0);
    endtask

    task automatic run(input string tag, input logic [31:0] addr, input bit wr,
                       input bit [2:0] sz, input logic [31:0] wd);
        logic [31:0] exp_rd, got_rd;
        bit          exp_er, got_er;
        int          exp_lat, got_lat;
        ref_access(addr, wr, sz, wd, exp_rd, exp_er, exp_lat);
        xact(addr, wr, sz, wd, got_rd, got_er, got_lat);
        check_eq({tag, ".lat"},  32'(got_lat), 32'(exp_lat));
        check_eq({tag, ".err"},  32'(got_er),  32'(exp_er));
        check_eq({tag, ".data"}, got_rd,       exp_rd);
    endtask

    initial begin
        logic [31:0] d_rd;
        bit          d_er;
        int          d_lat;
        logic [31:0] addr;
        bit [2:0]    sz;
        int          n;

        RST = 1'b1;
        req_valid = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst.ready", 32'(req_ready), 32'd0);
        check_eq("rst.valid", 32'(resp_valid), 32'd0);
        check_eq("rst.rdata", resp_rdata, 32'h0);
        check_eq("rst.err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        RST = 1'b0;
        #1;
        check_eq("rst.ready_release", 32'(req_ready), 32'd1);

        for (int w = 0; w < int'(DEPTH); w++) run("init", BASE + 32'(4 * w), 1'b1, 3'd4, $urandom);

        run("st_word",  BASE + 32'h10, 1'b1, 3'd4, 32'hDEAD_BEEF);
        run("ld_word",  BASE + 32'h10, 1'b0, 3'd4, 32'h0);
        run("st_byte",  BASE + 32'h12, 1'b1, 3'd1, 32'h1234_5655);
        run("ld_merge", BASE + 32'h10, 1'b0, 3'd4, 32'h0);
        check_eq("merge_value", {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}, 32'hDE55_BEEF);
        run("ld_half",  BASE + 32'h12, 1'b0, 3'd2, 32'h0);
        run("ld_byte",  BASE + 32'h13, 1'b0, 3'd1, 32'h0);
        run("err_ldw_mis", BASE + 32'h2, 1'b0, 3'd4, 32'h0);
        run("err_sth_mis", BASE + 32'h1, 1'b1, 3'd2, 32'hFFFF_FFFF);
        run("err_range",   BASE + 32'(4 * DEPTH), 1'b0, 3'd4, 32'h0);
        run("err_below",   BASE - 32'h4, 1'b1, 3'd4, 32'hFFFF_FFFF);
        run("err_2size",   BASE + 32'h0, 1'b1, 3'b101, 32'hFFFF_FFFF);
        run("err_nosize",  BASE + 32'h0, 1'b1, 3'b000, 32'hFFFF_FFFF);
        run("word0_kept",  BASE + 32'h0, 1'b0, 3'd4, 32'h0);

        // Reset asserted one cycle after accepting a byte store.
        @(negedge CLK);
        req_valid = 1'b1;
        req_addr  = BASE + 32'h10;
        req_write = 1'b1;
        {req_word, req_halfword, req_byte} = 3'd1;
        req_wdata = 32'h0000_00AA;
        check_eq("rmw_rst.ready_pre", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        scramble_inputs();
`ifdef MEM_RESP_BYTE_ENABLE_EN
        ref_access(BASE + 32'h10, 1'b1, 3'd1, 32'h0000_00AA, d_rd, d_er, d_lat);
`endif
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_eq("rmw_rst.ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge CLK);
        #1;
        check_eq("rmw_rst.valid", 32'(resp_valid), 32'd0);
        @(negedge CLK);
        check_eq("rmw_rst.ready_hold", 32'(req_ready), 32'd0);
        RST = 1'b0;
        #1;
        check_eq("rmw_rst.ready_after", 32'(req_ready), 32'd1);
        run("rmw_rst.reload", BASE + 32'h10, 1'b0, 3'd4, 32'h0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = BASE + 32'($urandom_range(0, NBYTES + 15));
            if ($urandom_range(0, 9) == 0) begin
                sz = 3'($urandom);
            end else begin
                n  = $urandom_range(0, 2);
                sz = 3'(1 << n);
                if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << n) - 1);
            end
            run("rand", addr, 1'($urandom), sz, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
